mem_req_scheduler: RTL and testbench

MEM_REQ_SCHEDULER -- requirements
Module: mem_req_scheduler

---
 rtl/mem_req_scheduler.sv | 168 ++++++++++++++++
 tb/tb_mem_req_scheduler.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_scheduler.sv
// Arbitrates icache/dcache requests onto one memory bus and routes tagged load
// completions back to their owners using a 16-entry tag ownership table.
module mem_req_scheduler #(
  parameter int XLEN            = 32,
  parameter int MAX_OUTSTANDING = 8,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            icache_req_valid,
  input  logic [XLEN-1:0] icache_req_addr,
  output logic            icache_req_ready,
  input  logic            dcache_req_valid,
  input  logic [1:0]      dcache_req_command,
  input  logic [XLEN-1:0] dcache_req_addr,
  input  logic [63:0]     dcache_req_data,
  output logic            dcache_req_ready,
  output logic [1:0]      proc2mem_command,
  output logic [XLEN-1:0] proc2mem_addr,
  output logic [63:0]     proc2mem_data,
  input  logic [3:0]      mem2proc_response,
  input  logic [63:0]     mem2proc_data,
  input  logic [3:0]      mem2proc_tag,
  output logic            icache_resp_valid,
  output logic [63:0]     icache_resp_data,
  output logic            dcache_resp_valid,
  output logic [63:0]     dcache_resp_data,
  output logic [3:0]      outstanding_count,
  output logic            sched_full,
  output logic            tag_error
);

  localparam logic [1:0] BUS_NONE    = 2'd0;
  localparam logic [1:0] BUS_LOAD    = 2'd1;
  localparam logic [1:0] BUS_STORE   = 2'd2;
  localparam logic [1:0] DEST_NONE   = 2'd0;
  localparam logic [1:0] DEST_ICACHE = 2'd1;
  localparam logic [1:0] DEST_DCACHE = 2'd2;
  localparam int         SW          = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {PRIO_DCACHE = 1'b0, PRIO_ICACHE = 1'b1} prio_e;

  prio_e          state_reg, state_next;
  logic [SW-1:0]  starve_reg, starve_next;
  logic [1:0]     owner_reg [16];
  logic [3:0]     count_reg, count_next;
  logic           icache_resp_valid_reg, dcache_resp_valid_reg, tag_error_reg;
  logic [63:0]    icache_resp_data_reg, dcache_resp_data_reg;

  logic           dc_is_load, dc_is_store, ic_ok, dc_ok;
  logic           grant_i, grant_d, mem_accept;
  logic           load_accept, free_hit, orphan_tag, alloc_clash, alloc_new;
  logic [1:0]     free_owner, alloc_dest;

  assign sched_full  = (count_reg == 4'(MAX_OUTSTANDING));
  assign dc_is_load  = (dcache_req_command == BUS_LOAD);
  assign dc_is_store = (dcache_req_command == BUS_STORE);
  // A full table only blocks loads; a pending store may still win the bus.
  assign ic_ok       = icache_req_valid && !sched_full;
  assign dc_ok       = dcache_req_valid && (dc_is_store || (dc_is_load && !sched_full));
  assign mem_accept  = (mem2proc_response != 4'd0);

  // Output process: grant and bus drive.
  always_comb begin
    grant_i          = 1'b0;
    grant_d          = 1'b0;
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    if (state_reg == PRIO_ICACHE) begin
      grant_i = ic_ok;
      grant_d = dc_ok && !ic_ok;
    end else begin
      grant_d = dc_ok;
      grant_i = ic_ok && !dc_ok;
    end
    if (grant_d) begin
      proc2mem_command = dcache_req_command;
      proc2mem_addr    = dcache_req_addr;
      if (dc_is_store) proc2mem_data = dcache_req_data;
    end else if (grant_i) begin
      proc2mem_command = BUS_LOAD;
      proc2mem_addr    = icache_req_addr;
    end
  end

  assign icache_req_ready = grant_i && mem_accept;
  assign dcache_req_ready = grant_d && mem_accept;

  // Starvation is forgotten once icache is served or withdraws while favoured,
  // so a stale saturated count cannot bounce the FSM straight back.
  always_comb begin
    starve_next = starve_reg;
    if (icache_req_ready)
      starve_next = '0;
    else if (state_reg == PRIO_ICACHE && !icache_req_valid)
      starve_next = '0;
    else if (state_reg == PRIO_DCACHE && icache_req_valid && starve_reg != SW'(STARVE_LIMIT))
      starve_next = starve_reg + 1'b1;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      PRIO_DCACHE: if (starve_next == SW'(STARVE_LIMIT)) state_next = PRIO_ICACHE;
      PRIO_ICACHE: if (icache_req_ready || !icache_req_valid) state_next = PRIO_DCACHE;
      default:     state_next = PRIO_DCACHE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg  <= PRIO_DCACHE;
      starve_reg <= '0;
    end else begin
      state_reg  <= state_next;
      starve_reg <= starve_next;
    end
  end

  assign free_owner  = owner_reg[mem2proc_tag];
  assign free_hit    = (mem2proc_tag != 4'd0) && (free_owner != DEST_NONE);
  assign orphan_tag  = (mem2proc_tag != 4'd0) && (free_owner == DEST_NONE);
  assign load_accept = icache_req_ready || (dcache_req_ready && dc_is_load);
  assign alloc_dest  = icache_req_ready ? DEST_ICACHE : DEST_DCACHE;
  // Reusing the tag that is being freed this very cycle is legal.
  assign alloc_clash = load_accept && (owner_reg[mem2proc_response] != DEST_NONE)
                       && !(free_hit && mem2proc_tag == mem2proc_response);
  assign alloc_new   = load_accept && !alloc_clash;

  always_comb begin
    count_next = count_reg;
    if (alloc_new && !free_hit)
      count_next = count_reg + 4'd1;
    else if (free_hit && !alloc_new)
      count_next = count_reg - 4'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) owner_reg[i] <= DEST_NONE;
      count_reg             <= '0;
      icache_resp_valid_reg <= 1'b0;
      icache_resp_data_reg  <= '0;
      dcache_resp_valid_reg <= 1'b0;
      dcache_resp_data_reg  <= '0;
      tag_error_reg         <= 1'b0;
    end else begin
      // Free first; a same-tag allocation below then wins.
      if (free_hit) owner_reg[mem2proc_tag] <= DEST_NONE;
      if (load_accept) owner_reg[mem2proc_response] <= alloc_dest;
      count_reg             <= count_next;
      icache_resp_valid_reg <= free_hit && (free_owner == DEST_ICACHE);
      icache_resp_data_reg  <= (free_hit && free_owner == DEST_ICACHE) ? mem2proc_data : '0;
      dcache_resp_valid_reg <= free_hit && (free_owner == DEST_DCACHE);
      dcache_resp_data_reg  <= (free_hit && free_owner == DEST_DCACHE) ? mem2proc_data : '0;
      tag_error_reg         <= tag_error_reg || orphan_tag || alloc_clash;
    end
  end

  assign outstanding_count = count_reg;
  assign icache_resp_valid = icache_resp_valid_reg;
  assign icache_resp_data  = icache_resp_data_reg;
  assign dcache_resp_valid = dcache_resp_valid_reg;
  assign dcache_resp_data  = dcache_resp_data_reg;
  assign tag_error         = tag_error_reg;

endmodule

// File: tb/tb_mem_req_scheduler.sv
// Self-checking bench for mem_req_scheduler: directed scenarios plus random
// traffic compared against a tag-ownership reference model.
module tb_mem_req_scheduler;
  localparam int XLEN = 32;
  localparam int MAXO = 8;
  localparam int SLIM = 4;
  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            ic_valid, dc_valid;
  logic [XLEN-1:0] ic_addr, dc_addr;
  logic [1:0]      dc_cmd;
  logic [63:0]     dc_data, mem_data;
  logic [3:0]      mem_resp, mem_tag;
  logic            icache_req_ready, dcache_req_ready;
  logic [1:0]      proc2mem_command;
  logic [XLEN-1:0] proc2mem_addr;
  logic [63:0]     proc2mem_data;
  logic            icache_resp_valid, dcache_resp_valid;
  logic [63:0]     icache_resp_data, dcache_resp_data;
  logic [3:0]      outstanding_count;
  logic            sched_full, tag_error;

  always #5 clock = ~clock;

  mem_req_scheduler #(.XLEN(XLEN), .MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(SLIM)) dut (
    .clock(clock), .reset(reset),
    .icache_req_valid(ic_valid), .icache_req_addr(ic_addr), .icache_req_ready(icache_req_ready),
    .dcache_req_valid(dc_valid), .dcache_req_command(dc_cmd), .dcache_req_addr(dc_addr),
    .dcache_req_data(dc_data), .dcache_req_ready(dcache_req_ready),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr), .proc2mem_data(proc2mem_data),
    .mem2proc_response(mem_resp), .mem2proc_data(mem_data), .mem2proc_tag(mem_tag),
    .icache_resp_valid(icache_resp_valid), .icache_resp_data(icache_resp_data),
    .dcache_resp_valid(dcache_resp_valid), .dcache_resp_data(dcache_resp_data),
    .outstanding_count(outstanding_count), .sched_full(sched_full), .tag_error(tag_error)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: who owns each tag (0 none, 1 icache, 2 dcache), how many
  // cycles in a row icache has been refused, and whether icache is now favoured.
  int          m_owner [16];
  int          m_count, m_denied;
  bit          m_ic_first, m_err;
  logic        m_ic_rv, m_dc_rv;
  logic [63:0] m_ic_rd, m_dc_rd;
  bit          last_ic_acc, last_dc_acc;
  logic        s_ic_ready, s_dc_ready;
  logic [1:0]  s_cmd;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_owner[i] = 0;
    m_count = 0; m_denied = 0; m_ic_first = 0; m_err = 0;
    m_ic_rv = 0; m_dc_rv = 0; m_ic_rd = '0; m_dc_rd = '0;
    last_ic_acc = 0; last_dc_acc = 0;
  endtask

  task automatic set_idle();
    ic_valid = 0; ic_addr = '0; dc_valid = 0; dc_cmd = BUS_NONE; dc_addr = '0; dc_data = '0;
    mem_resp = '0; mem_tag = '0; mem_data = '0;
  endtask

  // Called at posedge+1 with inputs already applied; returns at next posedge+1.
  task automatic step();
    bit full, ic_ok, dc_ok, gi, gd, acc, is_load;
    logic [1:0]      e_cmd;
    logic [XLEN-1:0] e_addr;
    logic [63:0]     e_data;
    int who;
    full  = (m_count == MAXO);
    ic_ok = ic_valid && !full;
    dc_ok = dc_valid && (dc_cmd == BUS_STORE || (dc_cmd == BUS_LOAD && !full));
    gi    = m_ic_first ? ic_ok : (ic_ok && !dc_ok);
    gd    = dc_ok && !gi;
    e_cmd  = gd ? dc_cmd  : (gi ? BUS_LOAD : BUS_NONE);
    e_addr = gd ? dc_addr : (gi ? ic_addr : '0);
    e_data = (gd && dc_cmd == BUS_STORE) ? dc_data : '0;
    acc    = (gi || gd) && (mem_resp != 0);
    #1;
    s_ic_ready = icache_req_ready; s_dc_ready = dcache_req_ready; s_cmd = proc2mem_command;
    check_eq("bus_cmd",   proc2mem_command, e_cmd);
    check_eq("bus_addr",  proc2mem_addr,    e_addr);
    check_eq("bus_data",  proc2mem_data,    e_data);
    check_eq("ic_ready",  icache_req_ready, gi && acc);
    check_eq("dc_ready",  dcache_req_ready, gd && acc);
    last_ic_acc = gi && acc;
    last_dc_acc = gd && acc;
    if (last_ic_acc) begin
      m_denied = 0; m_ic_first = 0;
    end else if (m_ic_first) begin
      if (!ic_valid) begin m_denied = 0; m_ic_first = 0; end
    end else if (ic_valid) begin
      if (m_denied < SLIM) m_denied++;
      if (m_denied == SLIM) m_ic_first = 1;
    end
    m_ic_rv = 0; m_ic_rd = '0; m_dc_rv = 0; m_dc_rd = '0;
    who = (mem_tag != 0) ? m_owner[mem_tag] : -1;
    if (who == 1) begin m_ic_rv = 1; m_ic_rd = mem_data; end
    if (who == 2) begin m_dc_rv = 1; m_dc_rd = mem_data; end
    if (who == 0) m_err = 1;
    if (who > 0) begin m_owner[mem_tag] = 0; m_count--; end
    is_load = last_ic_acc || (last_dc_acc && dc_cmd == BUS_LOAD);
    if (is_load) begin
      if (m_owner[mem_resp] != 0) m_err = 1;
      else m_count++;
      m_owner[mem_resp] = last_ic_acc ? 1 : 2;
    end
    @(posedge clock); #1;
    check_eq("ic_resp_valid", icache_resp_valid, m_ic_rv);
    check_eq("ic_resp_data",  icache_resp_data,  m_ic_rd);
    check_eq("dc_resp_valid", dcache_resp_valid, m_dc_rv);
    check_eq("dc_resp_data",  dcache_resp_data,  m_dc_rd);
    check_eq("count",         outstanding_count, m_count);
    check_eq("full",          sched_full,        m_count == MAXO);
    check_eq("tag_error",     tag_error,         m_err);
  endtask

  // Reset asserted mid-cycle and checked before the next edge.
  task automatic do_reset();
    #2; reset = 0; set_idle(); model_reset();
    #1;
    check_eq("rst_count",     outstanding_count, 0);
    check_eq("rst_full",      sched_full,        0);
    check_eq("rst_tag_error", tag_error,         0);
    check_eq("rst_ic_resp",   icache_resp_valid, 0);
    check_eq("rst_dc_resp",   dcache_resp_valid, 0);
    @(posedge clock); @(posedge clock); #1;
    reset = 1;
    @(posedge clock); #1;
  endtask

  task automatic rand_cycle(input bit allow_err);
    int q[$];
    int occ[$];
    if (last_ic_acc || !ic_valid) begin
      ic_valid = ($urandom_range(0, 2) != 0); ic_addr = $urandom;
    end
    if (last_dc_acc || !dc_valid) begin
      dc_valid = ($urandom_range(0, 2) != 0);
      dc_cmd   = ($urandom_range(0, 1) == 0) ? BUS_LOAD : BUS_STORE;
      dc_addr  = $urandom; dc_data = {$urandom, $urandom};
    end
    for (int t = 1; t < 16; t++) begin
      if (m_owner[t] == 0) q.push_back(t);
      else occ.push_back(t);
    end
    mem_tag = '0;
    if (occ.size() > 0 && $urandom_range(0, 2) == 0) mem_tag = 4'(occ[$urandom_range(0, occ.size() - 1)]);
    mem_resp = '0;
    if (q.size() > 0 && $urandom_range(0, 3) != 0) mem_resp = 4'(q[$urandom_range(0, q.size() - 1)]);
    if (mem_tag != 0 && $urandom_range(0, 3) == 0) mem_resp = mem_tag;
    if (allow_err) begin
      if ($urandom_range(0, 15) == 0) mem_tag  = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 15) == 0) mem_resp = 4'($urandom_range(1, 15));
    end
    mem_data = {$urandom, $urandom};
    step();
  endtask

  initial begin
    set_idle();
    model_reset();
    do_reset();

    // Both valid under dcache priority: dcache wins, tag 3 owned by dcache.
    ic_valid = 1; ic_addr = 32'h1000; dc_valid = 1; dc_cmd = BUS_LOAD; dc_addr = 32'h2000; mem_resp = 4'd3;
    step();
    check_eq("req040_dc_ready", s_dc_ready, 1);
    check_eq("req040_ic_ready", s_ic_ready, 0);
    check_eq("req040_count", outstanding_count, 1);
    dc_valid = 0; mem_resp = 0; mem_tag = 4'd3; mem_data = 64'h1234_5678_9abc_def0;
    step();
    check_eq("req040_owner_dc", dcache_resp_valid, 1);

    // Four dcache wins in a row starve icache; fifth cycle icache goes first.
    do_reset();
    ic_valid = 1; ic_addr = 32'h3000;
    for (int k = 0; k < 4; k++) begin
      dc_valid = 1; dc_cmd = BUS_STORE; dc_addr = 32'(k * 8); dc_data = 64'(k + 100); mem_resp = 4'd1;
      step();
      check_eq("req041_dc_first", s_dc_ready, 1);
    end
    dc_addr = 32'h40; step();
    check_eq("req041_ic_granted", s_ic_ready, 1);
    check_eq("req041_dc_held", s_dc_ready, 0);
    ic_addr = 32'h3040; mem_resp = 4'd2; step();
    check_eq("req041_back_to_dc", s_dc_ready, 1);

    // Icache load on tag 5 completes with 0xDEAD one cycle later.
    do_reset();
    ic_valid = 1; ic_addr = 32'h5000; mem_resp = 4'd5; step();
    ic_valid = 0; mem_resp = 0; mem_tag = 4'd5; mem_data = 64'hDEAD; step();
    check_eq("req042_valid", icache_resp_valid, 1);
    check_eq("req042_data", icache_resp_data, 64'hDEAD);
    check_eq("req042_count", outstanding_count, 0);
    set_idle(); step();

    // Eight loads fill the table; a ninth load is held off but a store issues.
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      dc_valid = 1; dc_cmd = BUS_LOAD; dc_addr = 32'(k * 64); mem_resp = 4'(k);
      step();
    end
    dc_addr = 32'h900; mem_resp = 4'd9; step();
    check_eq("req043_cmd_none", s_cmd, BUS_NONE);
    check_eq("req043_full", sched_full, 1);
    dc_cmd = BUS_STORE; dc_data = 64'hCAFE; step();
    check_eq("req043_store_cmd", s_cmd, BUS_STORE);
    check_eq("req043_store_ready", s_dc_ready, 1);

    // Tag 2 completes and is reallocated to icache in the same cycle.
    set_idle(); mem_tag = 4'd8; mem_data = 64'h8; step();
    ic_valid = 1; ic_addr = 32'h7700; mem_resp = 4'd2; mem_tag = 4'd2; mem_data = 64'h22; step();
    check_eq("req044_ic_ready", s_ic_ready, 1);
    check_eq("req044_count", outstanding_count, 7);
    check_eq("req044_no_err", tag_error, 0);
    ic_valid = 0; mem_resp = 0; mem_tag = 4'd2; mem_data = 64'h2222; step();
    check_eq("req044_new_owner", icache_resp_valid, 1);

    // Reset drops loads in flight; a late completion flags an error.
    set_idle(); do_reset();
    mem_tag = 4'd1; mem_data = 64'h11; step();
    check_eq("req045_no_ic", icache_resp_valid, 0);
    check_eq("req045_no_dc", dcache_resp_valid, 0);
    check_eq("req045_err", tag_error, 1);
    check_eq("req045_count", outstanding_count, 0);

    do_reset();
    for (int n = 0; n < 400; n++) rand_cycle(1'b0);
    do_reset();
    for (int n = 0; n < 300; n++) rand_cycle(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
